// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the register file's single write port between the pipeline
// writeback and the multiply/divide unit (MDU). MDU results are buffered in
// a small FIFO behind a valid/ready handshake. The pipeline always has
// priority, and the FIFO drains one entry per cycle whenever the port is free.
// A 32-bit scoreboard tracks registers that are still waiting for an MDU
// result. Decode is stalled on RAW or WAW hazards against those registers.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   pipe_wr/pipe_addr/pipe_data     pipeline writeback request
//   mdu_issue/mdu_issue_addr        MDU op issued (marks destination pending)
//   mdu_valid/mdu_addr/mdu_data     MDU result offer
//   mdu_ready                       buffer can accept a result
//   rd_addr1/rd_addr2               decode source registers
//   dec_dest_wr/dec_dest            decode destination register
//   stall                           decode must hold
//   rf_wr/rf_addr/rf_data           register file write port
//   pending                         scoreboard (bit 0 always 0)
//   buf_count                       number of buffered MDU results
module rf_wb_arbiter #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pipe_wr,
  input  logic [4:0]               pipe_addr,
  input  logic [DW-1:0]            pipe_data,
  input  logic                     mdu_issue,
  input  logic [4:0]               mdu_issue_addr,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_addr,
  input  logic [DW-1:0]            mdu_data,
  output logic                     mdu_ready,
  input  logic [4:0]               rd_addr1,
  input  logic [4:0]               rd_addr2,
  input  logic                     dec_dest_wr,
  input  logic [4:0]               dec_dest,
  output logic                     stall,
  output logic                     rf_wr,
  output logic [4:0]               rf_addr,
  output logic [DW-1:0]            rf_data,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic pipe_sel;
  logic pop;
  logic accept;
  logic enq;
  logic [31:0] pending_next;

  // A full buffer refuses even when it drains this cycle. This keeps
  // mdu_ready independent of the pipeline request.
  assign mdu_ready = (buf_count < CW'(DEPTH)) && !reset;
  assign accept    = mdu_valid && mdu_ready;
  // A result for r0 completes the handshake but is dropped.
  assign enq       = accept && (mdu_addr != 5'd0);
  assign pipe_sel  = pipe_wr && (pipe_addr != 5'd0);
  assign pop       = !pipe_sel && (buf_count != '0) && !reset;

  always_comb begin
    rf_wr   = 1'b0;
    rf_addr = '0;
    rf_data = '0;
    if (!reset) begin
      if (pipe_sel) begin
        rf_wr   = 1'b1;
        rf_addr = pipe_addr;
        rf_data = pipe_data;
      end else if (buf_count != '0) begin
        rf_wr   = 1'b1;
        rf_addr = fifo_addr[rd_ptr];
        rf_data = fifo_data[rd_ptr];
      end
    end
  end

  // The clear is applied first, so a set in the same cycle wins.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[fifo_addr[rd_ptr]] = 1'b0;
    if (mdu_issue && (mdu_issue_addr != 5'd0))
      pending_next[mdu_issue_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    stall = 1'b0;
    if ((rd_addr1 != 5'd0) && pending[rd_addr1])
      stall = 1'b1;
    if ((rd_addr2 != 5'd0) && pending[rd_addr2])
      stall = 1'b1;
    if (dec_dest_wr && (dec_dest != 5'd0) && pending[dec_dest])
      stall = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      buf_count <= '0;
      pending   <= '0;
    end else begin
      pending <= pending_next;
      if (enq)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (enq && !pop)
        buf_count <= buf_count + 1'b1;
      else if (pop && !enq)
        buf_count <= buf_count - 1'b1;
    end
  end

  // Storage needs no reset; the occupancy count alone qualifies it.
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_addr[wr_ptr] <= mdu_addr;
      fifo_data[wr_ptr] <= mdu_data;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned DW    = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_wr;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_addr;
  logic        mdu_valid;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic        dec_dest_wr;
  logic [4:0]  dec_dest;
  logic        stall;
  logic        rf_wr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pending;
  logic [1:0]  buf_count;

  rf_wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .mdu_issue(mdu_issue), .mdu_issue_addr(mdu_issue_addr),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .dec_dest_wr(dec_dest_wr), .dec_dest(dec_dest),
    .stall(stall), .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_data(rf_data),
    .pending(pending), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pw;  logic [4:0] pa; logic [31:0] pd;
    logic        iss; logic [4:0] ia;
    logic        mv;  logic [4:0] ma; logic [31:0] md;
    logic [4:0]  r1;  logic [4:0] r2; logic dw; logic [4:0] dd;
    logic        e_wr; logic [4:0] e_addr; logic [31:0] e_data;
    logic        e_stall; logic e_ready; logic [1:0] e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  // Reference model: the buffer is an ordered queue and the scoreboard is a set of registers.
  ent_t        mq[$];
  logic [31:0] mpend;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    pipe_wr = v.pw;   pipe_addr = v.pa;   pipe_data = v.pd;
    mdu_issue = v.iss; mdu_issue_addr = v.ia;
    mdu_valid = v.mv; mdu_addr = v.ma;    mdu_data = v.md;
    rd_addr1 = v.r1;  rd_addr2 = v.r2;    dec_dest_wr = v.dw; dec_dest = v.dd;
  endtask

  task automatic idle();
    vec_t v;
    v = '{0,0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0, 0,0,0};
    apply(v);
  endtask

  task automatic model_clear();
    mq.delete();
    mpend = '0;
  endtask

  task automatic model_check(input string tag);
    logic        e_wr, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    e_wr = 0; e_addr = 0; e_data = 0;
    if (pipe_wr && pipe_addr != 0) begin
      e_wr = 1; e_addr = pipe_addr; e_data = pipe_data;
    end else if (mq.size() > 0) begin
      e_wr = 1; e_addr = mq[0].a; e_data = mq[0].d;
    end
    e_stall = (rd_addr1 != 0 && mpend[rd_addr1]) ||
              (rd_addr2 != 0 && mpend[rd_addr2]) ||
              (dec_dest_wr && dec_dest != 0 && mpend[dec_dest]);
    chk({tag, ".rf_wr"},     32'(rf_wr),     32'(e_wr));
    chk({tag, ".rf_addr"},   32'(rf_addr),   32'(e_addr));
    chk({tag, ".rf_data"},   rf_data,        e_data);
    chk({tag, ".stall"},     32'(stall),     32'(e_stall));
    chk({tag, ".mdu_ready"}, 32'(mdu_ready), 32'(mq.size() < DEPTH));
    chk({tag, ".buf_count"}, 32'(buf_count), 32'(mq.size()));
    chk({tag, ".pending"},   pending,        mpend);
  endtask

  task automatic model_update();
    logic pipe_busy, do_pop, do_acc;
    pipe_busy = pipe_wr && pipe_addr != 0;
    do_pop    = !pipe_busy && mq.size() > 0;
    do_acc    = mdu_valid && mq.size() < DEPTH;
    if (do_pop) begin
      mpend[mq[0].a] = 1'b0;
      void'(mq.pop_front());
    end
    if (do_acc && mdu_addr != 0)
      mq.push_back('{a: mdu_addr, d: mdu_data});
    if (mdu_issue && mdu_issue_addr != 0)
      mpend[mdu_issue_addr] = 1'b1;
    mpend[0] = 1'b0;
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    model_check(tag);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    model_clear();
    #2 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t tbl[26];

  initial begin
    // Sequences for the ordinary cases, starting from an empty buffer and a clear scoreboard.
    //        pw pa pd      iss ia  mv ma md             r1 r2 dw dd  wr ad data           st rdy cnt
    tbl[0]  = '{0, 0, 0,     1, 8,  0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[1]  = '{0, 0, 0,     0, 0,  0, 0, 0,            8, 0, 0, 0,  0, 0, 0,            1, 1, 0};
    tbl[2]  = '{0, 0, 0,     0, 0,  1, 8, 32'hDEADBEEF, 8, 0, 0, 0,  0, 0, 0,            1, 1, 0};
    tbl[3]  = '{0, 0, 0,     0, 0,  0, 0, 0,            8, 0, 0, 0,  1, 8, 32'hDEADBEEF, 1, 1, 1};
    tbl[4]  = '{0, 0, 0,     0, 0,  0, 0, 0,            8, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[5]  = '{1, 3, 'hA0,  0, 0,  1, 9, 'h11,         0, 0, 0, 0,  1, 3, 'hA0,         0, 1, 0};
    tbl[6]  = '{1, 3, 'hA1,  0, 0,  1, 10,'h22,         0, 0, 0, 0,  1, 3, 'hA1,         0, 1, 1};
    tbl[7]  = '{1, 3, 'hA2,  0, 0,  1, 11,'h33,         0, 0, 0, 0,  1, 3, 'hA2,         0, 0, 2};
    tbl[8]  = '{1, 3, 'hA3,  0, 0,  1, 11,'h33,         0, 0, 0, 0,  1, 3, 'hA3,         0, 0, 2};
    tbl[9]  = '{0, 0, 0,     0, 0,  1, 11,'h33,         0, 0, 0, 0,  1, 9, 'h11,         0, 0, 2};
    tbl[10] = '{0, 0, 0,     0, 0,  1, 11,'h33,         0, 0, 0, 0,  1, 10,'h22,         0, 1, 1};
    tbl[11] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0, 0, 0,  1, 11,'h33,         0, 1, 1};
    tbl[12] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[13] = '{0, 0, 0,     0, 0,  1, 0, 'h55,         0, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[14] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[15] = '{0, 0, 0,     1, 12, 0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[16] = '{0, 0, 0,     0, 0,  1, 12,'hC0,         0, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[17] = '{0, 0, 0,     1, 12, 0, 0, 0,            0, 12,0, 0,  1, 12,'hC0,         1, 1, 1};
    tbl[18] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 12,0, 0,  0, 0, 0,            1, 1, 0};
    tbl[19] = '{0, 0, 0,     1, 7,  0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[20] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0, 1, 7,  0, 0, 0,            1, 1, 0};
    tbl[21] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0, 0, 7,  0, 0, 0,            0, 1, 0};
    tbl[22] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0, 1, 0,  0, 0, 0,            0, 1, 0};
    tbl[23] = '{0, 0, 0,     0, 0,  1, 13,'h77,         0, 0, 0, 0,  0, 0, 0,            0, 1, 0};
    tbl[24] = '{1, 0, 'hFF,  0, 0,  0, 0, 0,            0, 0, 0, 0,  1, 13,'h77,         0, 1, 1};
    tbl[25] = '{0, 0, 0,     0, 0,  0, 0, 0,            0, 0, 0, 0,  0, 0, 0,            0, 1, 0};

    reset = 1'b1;
    idle();
    model_clear();
    #1;
    chk("rst.rf_wr",     32'(rf_wr),     32'd0);
    chk("rst.mdu_ready", 32'(mdu_ready), 32'd0);
    chk("rst.buf_count", 32'(buf_count), 32'd0);
    chk("rst.pending",   pending,        32'd0);
    #11 reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 26; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d.rf_wr", i),     32'(rf_wr),     32'(tbl[i].e_wr));
      chk($sformatf("vec%0d.rf_addr", i),   32'(rf_addr),   32'(tbl[i].e_addr));
      chk($sformatf("vec%0d.rf_data", i),   rf_data,        tbl[i].e_data);
      chk($sformatf("vec%0d.stall", i),     32'(stall),     32'(tbl[i].e_stall));
      chk($sformatf("vec%0d.mdu_ready", i), 32'(mdu_ready), 32'(tbl[i].e_ready));
      chk($sformatf("vec%0d.buf_count", i), 32'(buf_count), 32'(tbl[i].e_cnt));
      model_check($sformatf("mvec%0d", i));
      @(posedge clk);
      model_update();
      #1;
    end

    // Reset in the middle of operation, with a full buffer and register 5 pending.
    idle();
    pulse_reset();
    mdu_issue = 1; mdu_issue_addr = 5; mdu_valid = 1; mdu_addr = 20; mdu_data = 32'h1;
    tick("fill0");
    mdu_issue = 0; pipe_wr = 1; pipe_addr = 3; pipe_data = 32'hBB;
    mdu_addr = 21; mdu_data = 32'h2;
    tick("fill1");
    mdu_valid = 0;
    @(negedge clk);
    model_check("full");
    chk("full.buf_count", 32'(buf_count), 32'd2);
    chk("full.pend5",     32'(pending[5]), 32'd1);
    mdu_valid = 1; mdu_addr = 22;
    #1 reset = 1'b1;
    model_clear();
    #1;
    chk("arst.buf_count", 32'(buf_count), 32'd0);
    chk("arst.pending",   pending,        32'd0);
    chk("arst.rf_wr",     32'(rf_wr),     32'd0);
    chk("arst.mdu_ready", 32'(mdu_ready), 32'd0);
    @(posedge clk); #1;
    chk("arst_hold.buf_count", 32'(buf_count), 32'd0);
    chk("arst_hold.rf_wr",     32'(rf_wr),     32'd0);
    reset = 1'b0;
    mdu_valid = 0; pipe_wr = 0;
    #1;
    chk("rel.mdu_ready", 32'(mdu_ready), 32'd1);
    chk("rel.buf_count", 32'(buf_count), 32'd0);
    chk("rel.pending",   pending,        32'd0);
    chk("rel.rf_wr",     32'(rf_wr),     32'd0);
    tick("post_rel");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      pipe_wr        = ($urandom_range(0, 2) == 0);
      pipe_addr      = 5'($urandom_range(0, 7));
      pipe_data      = $urandom;
      mdu_issue      = ($urandom_range(0, 3) == 0);
      mdu_issue_addr = 5'($urandom_range(0, 7));
      mdu_valid      = ($urandom_range(0, 1) == 0);
      mdu_addr       = 5'($urandom_range(0, 7));
      mdu_data       = $urandom;
      rd_addr1       = 5'($urandom_range(0, 7));
      rd_addr2       = 5'($urandom_range(0, 7));
      dec_dest_wr    = ($urandom_range(0, 1) == 0);
      dec_dest       = 5'($urandom_range(0, 7));
      tick($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
